dual_dequeue_ctrl: RTL and testbench

DUAL_DEQUEUE_CTRL -- requirements
Module: dual_dequeue_ctrl

---
 rtl/dual_dequeue_ctrl.sv | 117 +++++++++++
 tb/tb_dual_dequeue_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dual_dequeue_ctrl.sv
// Dual-read FIFO dequeue controller feeding a 2-slot in-order output buffer.
// Read enables depend combinationally on consumer ready so the buffer refills with no bubble.
module dual_dequeue_ctrl #(
    parameter int DATA_WIDTH = 5,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNT_WIDTH-1:0]  fifo_num_i,
    input  logic [DATA_WIDTH-1:0] rdata_first_i,
    input  logic [DATA_WIDTH-1:0] rdata_second_i,
    output logic                  rd_first_en_o,
    output logic                  rd_second_en_o,
    input  logic                  flush_i,
    output logic                  out0_valid_o,
    output logic [DATA_WIDTH-1:0] out0_data_o,
    output logic                  out1_valid_o,
    output logic [DATA_WIDTH-1:0] out1_data_o,
    input  logic [1:0]            out_ready_i
);

    logic                  r_v0;
    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_d0;
    logic [DATA_WIDTH-1:0] r_d1;

    logic                  w_fire0;
    logic                  w_fire1;
    logic [1:0]            w_occ;
    logic [1:0]            w_cons;
    logic [1:0]            w_rem;
    logic [1:0]            w_free;
    logic [1:0]            w_avail;
    logic [1:0]            w_fetch;
    logic [1:0]            w_total;
    logic [DATA_WIDTH-1:0] w_rem0;

    logic                  w_v0_nxt;
    logic                  w_v1_nxt;
    logic [DATA_WIDTH-1:0] w_d0_nxt;
    logic [DATA_WIDTH-1:0] w_d1_nxt;

    assign w_fire0 = r_v0 & out_ready_i[0];
    assign w_fire1 = w_fire0 & r_v1 & out_ready_i[1];

    assign w_occ  = {1'b0, r_v0} + {1'b0, r_v1};
    assign w_cons = {1'b0, w_fire0} + {1'b0, w_fire1};
    assign w_rem  = w_occ - w_cons;
    assign w_free = 2'd2 - w_rem;

    // Any count of two or more lets both read ports pop.
    assign w_avail = (fifo_num_i > CNT_WIDTH'(1)) ? 2'd2 : fifo_num_i[1:0];

    always_comb begin
        w_fetch = (w_free < w_avail) ? w_free : w_avail;
        if (rst || flush_i) begin
            w_fetch = 2'd0;
        end
    end

    assign rd_first_en_o  = (w_fetch != 2'd0);
    assign rd_second_en_o = (w_fetch == 2'd2);

    // With one survivor, it is slot1 if lane 0 fired, else slot0.
    assign w_rem0  = w_fire0 ? r_d1 : r_d0;
    assign w_total = w_rem + w_fetch;

    always_comb begin
        w_d0_nxt = r_d0;
        w_d1_nxt = r_d1;
        w_v0_nxt = (w_total != 2'd0);
        w_v1_nxt = (w_total == 2'd2);
        unique case (w_rem)
            2'd0: begin
                if (w_fetch != 2'd0) begin
                    w_d0_nxt = rdata_first_i;
                end
                if (w_fetch == 2'd2) begin
                    w_d1_nxt = rdata_second_i;
                end
            end
            2'd1: begin
                w_d0_nxt = w_rem0;
                if (w_fetch != 2'd0) begin
                    w_d1_nxt = rdata_first_i;
                end
            end
            default: begin
                w_d0_nxt = r_d0;
                w_d1_nxt = r_d1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_d0 <= '0;
            r_d1 <= '0;
        end else if (flush_i) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
        end else begin
            r_v0 <= w_v0_nxt;
            r_v1 <= w_v1_nxt;
            r_d0 <= w_d0_nxt;
            r_d1 <= w_d1_nxt;
        end
    end

    assign out0_valid_o = r_v0;
    assign out1_valid_o = r_v1;
    assign out0_data_o  = r_d0;
    assign out1_data_o  = r_d1;

endmodule

// File: tb/tb_dual_dequeue_ctrl.sv
// Randomized bench for dual_dequeue_ctrl against a queue-based model,
// with directed scenarios holding literal expectations.
module tb_dual_dequeue_ctrl;

    localparam int DW = 5;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] fifo_num_i;
    logic [DW-1:0] rdata_first_i;
    logic [DW-1:0] rdata_second_i;
    logic          rd_first_en_o;
    logic          rd_second_en_o;
    logic          flush_i;
    logic          out0_valid_o;
    logic [DW-1:0] out0_data_o;
    logic          out1_valid_o;
    logic [DW-1:0] out1_data_o;
    logic [1:0]    out_ready_i;

    always #5 clk = ~clk;

    dual_dequeue_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_num_i     (fifo_num_i),
        .rdata_first_i  (rdata_first_i),
        .rdata_second_i (rdata_second_i),
        .rd_first_en_o  (rd_first_en_o),
        .rd_second_en_o (rd_second_en_o),
        .flush_i        (flush_i),
        .out0_valid_o   (out0_valid_o),
        .out0_data_o    (out0_data_o),
        .out1_valid_o   (out1_valid_o),
        .out1_data_o    (out1_data_o),
        .out_ready_i    (out_ready_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] fifo[$];
    logic [DW-1:0] buff[$];
    logic [1:0]    last_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive, check read enables, clock, check buffer outputs.
    task automatic step(input logic rs, input logic fl, input logic [1:0] rdy);
        int occ, k, n, f;
        logic [1:0] exp_rd;
        rst            = rs;
        flush_i        = fl;
        out_ready_i    = rdy;
        fifo_num_i     = CW'(fifo.size());
        rdata_first_i  = (fifo.size() > 0) ? fifo[0] : DW'($urandom);
        rdata_second_i = (fifo.size() > 1) ? fifo[1] : DW'($urandom);
        #1;
        occ = buff.size();
        k = 0;
        if (occ >= 1 && rdy[0]) begin
            k = 1;
            if (occ == 2 && rdy[1]) k = 2;
        end
        n = (fifo.size() >= 2) ? 2 : fifo.size();
        f = 2 - (occ - k);
        if (n < f) f = n;
        if (rs || fl) f = 0;
        exp_rd = (f == 0) ? 2'b00 : (f == 1) ? 2'b01 : 2'b11;
        last_rd = {rd_second_en_o, rd_first_en_o};
        chk("rd_en", 32'(last_rd), 32'(exp_rd));
        @(posedge clk);
        if (rs || fl) begin
            buff.delete();
        end else begin
            repeat (k) void'(buff.pop_front());
            repeat (f) buff.push_back(fifo.pop_front());
        end
        @(negedge clk);
        chk("out0_valid", 32'(out0_valid_o), 32'(buff.size() >= 1));
        chk("out1_valid", 32'(out1_valid_o), 32'(buff.size() == 2));
        if (buff.size() >= 1) chk("out0_data", 32'(out0_data_o), 32'(buff[0]));
        if (buff.size() == 2) chk("out1_data", 32'(out1_data_o), 32'(buff[1]));
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        out_ready_i = 2'b00;
        fifo_num_i = '0;
        rdata_first_i = '0;
        rdata_second_i = '0;
        @(negedge clk);

        step(1'b1, 1'b0, 2'b11);
        fifo.push_back(5'd9);
        step(1'b1, 1'b0, 2'b00);
        chk("rst_rd", 32'(last_rd), 32'd0);
        chk("rst_d0", 32'(out0_data_o), 32'd0);
        chk("rst_d1", 32'(out1_data_o), 32'd0);
        fifo.delete();

        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 2'($urandom));
            chk("empty_rd", 32'(last_rd), 32'd0);
            chk("empty_v", 32'({out1_valid_o, out0_valid_o}), 32'd0);
        end

        fifo.push_back(5'h03);
        step(1'b0, 1'b0, 2'b00);
        chk("one_rd", 32'(last_rd), 32'b01);
        chk("one_out0", 32'({out0_valid_o, out0_data_o}), 32'h23);
        chk("one_v1", 32'(out1_valid_o), 32'd0);
        step(1'b0, 1'b0, 2'b00);
        chk("one_rd_idle", 32'(last_rd), 32'd0);

        step(1'b0, 1'b1, 2'b11);
        fifo.push_back(5'd5);
        fifo.push_back(5'd6);
        step(1'b0, 1'b0, 2'b00);
        chk("fill56_rd", 32'(last_rd), 32'b11);
        fifo.push_back(5'd7);
        step(1'b0, 1'b0, 2'b10);
        chk("r10_rd", 32'(last_rd), 32'd0);
        chk("r10_out", 32'({out0_data_o, out1_data_o}), 32'({5'd5, 5'd6}));
        step(1'b0, 1'b0, 2'b01);
        chk("r01_rd", 32'(last_rd), 32'b01);
        chk("r01_out", 32'({out0_data_o, out1_data_o}), 32'({5'd6, 5'd7}));

        step(1'b0, 1'b1, 2'b00);
        for (int i = 1; i <= 8; i++) fifo.push_back(DW'(i));
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 2'b11);
            chk("stream_rd", 32'(last_rd), 32'b11);
            chk("stream_out", 32'({out0_data_o, out1_data_o}),
                32'({DW'(2 * i + 1), DW'(2 * i + 2)}));
        end

        for (int i = 9; i <= 12; i++) fifo.push_back(DW'(i));
        step(1'b0, 1'b1, 2'b11);
        chk("flush_rd", 32'(last_rd), 32'd0);
        chk("flush_v", 32'({out1_valid_o, out0_valid_o}), 32'd0);
        step(1'b0, 1'b0, 2'b11);
        chk("resume_rd", 32'(last_rd), 32'b11);
        chk("resume_out", 32'({out0_data_o, out1_data_o}), 32'({5'd9, 5'd10}));

        for (int i = 0; i < 600; i++) begin
            if (fifo.size() < 5 && ($urandom % 2) == 0) begin
                repeat ($urandom_range(0, 3)) fifo.push_back(DW'($urandom));
            end
            step(($urandom % 40) == 0, ($urandom % 15) == 0, 2'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
